mem_stage: RTL and testbench

- Memory stage of the non-forwarding RV32I pipeline: consumer of the EX-stage results (alu_data_e as address/result, rs2_data_e as store data).
- Contains the EX/MEM pipeline register, a data-memory request/acknowledge handshake with timeout, store lane steering and load extraction/extension.
- Drives the MEM/WB register and a stall back to the hazard logic.

---
 rtl/mem_pkg.sv | 54 +++++
 rtl/mem_stage_lsu_align.sv | 56 +++++
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the RV32I memory stage: funct3 codes, FSM state,
// M/W register layouts and the alignment rule used on both M and EX.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic        mem_wren;
    logic        wb_sel;
    logic        rd_wren;
  } m_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_wren;
    logic        wb_sel;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        misalign;
    logic        bus_err;
  } w_reg_t;

  // Undefined funct3 codes are treated as word accesses.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic r;
    unique case (f3)
      F3_B, F3_BU: r = 1'b0;
      F3_H, F3_HU: r = lo[0];
      default:     r = |lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store steering (wdata/bmask), load byte/half
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  bmask,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic        is_b;
  logic        is_h;
  logic [31:0] shifted;
  logic [15:0] half;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);

  assign misalign = misaligned(funct3, addr_lo);

  always_comb begin
    wdata = rs2;
    bmask = 4'b1111;
    unique case (1'b1)
      is_b: begin
        wdata = {4{rs2[7:0]}};
        bmask = 4'b0001 << addr_lo;
      end
      is_h: begin
        wdata = {2{rs2[15:0]}};
        bmask = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = rdata;
    unique case (funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_H:    ld_data = {{16{half[15]}}, half};
      F3_HU:   ld_data = {16'd0, half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/M register, dmem req/ack handshake with timeout,
// MEM/WB register and stall_m back to hazard logic.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        valid_e,
  input  logic [31:0] pc_e,
  input  logic [31:0] instr_e,
  input  logic [31:0] alu_data_e,
  input  logic [31:0] rs2_data_e,
  input  logic        mem_wren_e,
  input  logic        wb_sel_e,
  input  logic        rd_wren_e,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_bmask,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        valid_w,
  output logic [31:0] pc_w,
  output logic [4:0]  rd_w,
  output logic        rd_wren_w,
  output logic        wb_sel_w,
  output logic [31:0] alu_data_w,
  output logic [31:0] ld_data_w,
  output logic        misalign_w,
  output logic        bus_err_w
);

  m_reg_t           m;
  m_reg_t           m_in;
  w_reg_t           w;
  w_reg_t           w_n;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  logic        is_mem;
  logic        is_store;
  logic        is_load;
  logic        in_req;
  logic        ack;
  logic        timeout;
  logic        mis;
  logic        done;
  logic        cap_mem;
  logic [31:0] st_wdata;
  logic [3:0]  st_bmask;
  logic [31:0] ld_ext;
  logic        lsu_mis;
  logic        unused_instr;

  assign unused_instr = ^{instr_e[31:15], instr_e[6:0]};

  assign m_in = '{
    valid:    valid_e,
    pc:       pc_e,
    funct3:   instr_e[14:12],
    rd:       instr_e[11:7],
    alu:      alu_data_e,
    rs2:      rs2_data_e,
    mem_wren: mem_wren_e,
    wb_sel:   wb_sel_e,
    rd_wren:  rd_wren_e
  };

  lsu_align u_lsu (
    .funct3   (m.funct3),
    .addr_lo  (m.alu[1:0]),
    .rs2      (m.rs2),
    .rdata    (dmem_rdata),
    .wdata    (st_wdata),
    .bmask    (st_bmask),
    .ld_data  (ld_ext),
    .misalign (lsu_mis)
  );

  assign is_mem   = m.valid & (m.mem_wren | m.wb_sel);
  assign is_store = m.mem_wren;
  assign is_load  = m.wb_sel & ~m.mem_wren;
  assign mis      = is_mem & lsu_mis;

  assign in_req  = (state == REQ);
  assign ack     = in_req & dmem_ack;
  assign timeout = in_req & ~dmem_ack &
                   (cnt == CNT_W'(TIMEOUT - 1));
  assign stall_m = in_req & ~dmem_ack & ~timeout;
  assign done    = m.valid & (~is_mem | mis | ack | timeout);

  // Alignment is checked on the EX side so REQ is entered only for
  // accesses that will actually go out on the bus.
  assign cap_mem = valid_e & (mem_wren_e | wb_sel_e) &
                   ~misaligned(instr_e[14:12], alu_data_e[1:0]);

  always_comb begin
    state_n = IDLE;
    cnt_n   = '0;
    unique case (state)
      IDLE: begin
        if (cap_mem) state_n = REQ;
      end
      REQ: begin
        if (stall_m) begin
          state_n = REQ;
          cnt_n   = cnt + 1'b1;
        end else if (cap_mem) begin
          state_n = REQ;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_n = '0;
    if (done) begin
      w_n.valid    = 1'b1;
      w_n.pc       = m.pc;
      w_n.rd       = m.rd;
      w_n.rd_wren  = m.rd_wren & ~mis & ~timeout;
      w_n.wb_sel   = m.wb_sel;
      w_n.alu      = m.alu;
      w_n.ld       = (is_load & ack) ? ld_ext : 32'd0;
      w_n.misalign = mis;
      w_n.bus_err  = timeout;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      m     <= '0;
      w     <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (!stall_m) m <= m_in;
      w     <= w_n;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign dmem_req   = in_req;
  assign dmem_we    = in_req & is_store;
  assign dmem_addr  = in_req ? {m.alu[31:2], 2'b00} : 32'd0;
  assign dmem_wdata = (in_req & is_store) ? st_wdata : 32'd0;
  assign dmem_bmask = in_req ? (is_store ? st_bmask : 4'b1111)
                             : 4'b0000;

  assign valid_w    = w.valid;
  assign pc_w       = w.pc;
  assign rd_w       = w.rd;
  assign rd_wren_w  = w.rd_wren;
  assign wb_sel_w   = w.wb_sel;
  assign alu_data_w = w.alu;
  assign ld_data_w  = w.ld;
  assign misalign_w = w.misalign;
  assign bus_err_w  = w.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a byte-level reference
// memory predicts W entries; a word-level device model answers dmem.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        valid_e = 1'b0;
  logic [31:0] pc_e = '0;
  logic [31:0] instr_e = '0;
  logic [31:0] alu_data_e = '0;
  logic [31:0] rs2_data_e = '0;
  logic        mem_wren_e = 1'b0;
  logic        wb_sel_e = 1'b0;
  logic        rd_wren_e = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_bmask;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_m;
  logic        valid_w;
  logic [31:0] pc_w;
  logic [4:0]  rd_w;
  logic        rd_wren_w;
  logic        wb_sel_w;
  logic [31:0] alu_data_w;
  logic [31:0] ld_data_w;
  logic        misalign_w;
  logic        bus_err_w;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .valid_e(valid_e), .pc_e(pc_e), .instr_e(instr_e),
    .alu_data_e(alu_data_e), .rs2_data_e(rs2_data_e),
    .mem_wren_e(mem_wren_e), .wb_sel_e(wb_sel_e),
    .rd_wren_e(rd_wren_e),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_bmask(dmem_bmask), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_m(stall_m),
    .valid_w(valid_w), .pc_w(pc_w), .rd_w(rd_w),
    .rd_wren_w(rd_wren_w), .wb_sel_w(wb_sel_w),
    .alu_data_w(alu_data_w), .ld_data_w(ld_data_w),
    .misalign_w(misalign_w), .bus_err_w(bus_err_w)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rwe;
    logic        wbs;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        mis;
    logic        berr;
    int          stalls;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  bmask;
    logic [31:0] wdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int   lat_q[$];

  int          ref_mem[int];
  logic [31:0] dev_mem[int];

  int n_chk = 0;
  int n_fail = 0;
  int stall_acc = 0;
  bit flush = 1'b0;
  bit stray_ack = 1'b0;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int wa);
    return (32'(wa) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int ref_rd(input int a);
    logic [31:0] wv;
    if (ref_mem.exists(a)) return ref_mem[a];
    wv = init_word(a - (a % 4));
    return int'((wv >> (8 * (a % 4))) & 32'hFF);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(int'(a))) return dev_mem[int'(a)];
    return init_word(int'(a));
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. lat = ack cycle index.
  task automatic issue(input bit v, input int kind,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd,
                       input bit rwe, input int lat);
    logic [31:0] pc;
    logic [31:0] instr;
    exp_t        e;
    req_t        r;
    int          sz;
    int          k;
    bit          mem;
    bit          mis;
    bit          berr;
    longint      val;
    longint      one;
    one   = 1;
    pc    = $urandom & 32'hFFFF_FFFC;
    instr = $urandom;
    instr[14:12] = f3;
    instr[11:7]  = rd;
    valid_e    = v;
    pc_e       = pc;
    instr_e    = instr;
    alu_data_e = addr;
    rs2_data_e = rs2;
    mem_wren_e = (kind == 2);
    wb_sel_e   = (kind == 1);
    rd_wren_e  = rwe;
    if (v) begin
      mem  = (kind != 0);
      sz   = size_of(f3);
      mis  = mem && ((int'(addr[1:0]) % sz) != 0);
      berr = mem && !mis && (lat >= TIMEOUT);
      e.pc     = pc;
      e.rd     = rd;
      e.rwe    = rwe && !mis && !berr;
      e.wbs    = (kind == 1);
      e.alu    = addr;
      e.ld     = 32'd0;
      e.mis    = mis;
      e.berr   = berr;
      e.stalls = (mem && !mis) ? (berr ? TIMEOUT - 1 : lat) : 0;
      if (mem && !mis) begin
        r.addr = addr & ~32'd3;
        r.we   = (kind == 2);
        if (kind == 2) begin
          r.bmask = 4'(((1 << sz) - 1) << int'(addr[1:0]));
          if (sz == 1)      r.wdata = 32'(rs2[7:0]) * 32'h01010101;
          else if (sz == 2) r.wdata = 32'(rs2[15:0]) * 32'h00010001;
          else              r.wdata = rs2;
        end else begin
          r.bmask = 4'hF;
          r.wdata = 32'd0;
        end
        req_q.push_back(r);
        lat_q.push_back(lat);
        if (!berr) begin
          if (kind == 2) begin
            for (int i = 0; i < sz; i++)
              ref_mem[int'(addr) + i] = int'((rs2 >> (8 * i)) & 32'hFF);
          end else begin
            val = 0;
            for (int i = 0; i < sz; i++)
              val += longint'(ref_rd(int'(addr) + i)) << (8 * i);
            if (sz < 4 && !f3[2] && val >= (one << (8 * sz - 1)))
              val -= (one << (8 * sz));
            e.ld = 32'(val);
          end
        end
      end
      exp_q.push_back(e);
    end
    k = 0;
    forever begin
      @(negedge i_clk);
      #1;
      if (!stall_m) break;
      k++;
      if (k > 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL stall_bound got=%0d exp<=100", k);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "stall never released");
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  // Device model: answers requests after the planned latency.
  bit   r_active = 1'b0;
  int   r_cyc = 0;
  int   r_lat = 0;
  req_t r_cur;
  initial begin
    logic [31:0] wv;
    forever begin
      @(negedge i_clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      if (flush) begin
        r_active = 1'b0;
        flush    = 1'b0;
      end
      if (dmem_req) begin
        if (!r_active) begin
          if (lat_q.size() == 0) begin
            chk("unexpected_req", {127'd0, dmem_req}, 128'd0);
          end else begin
            r_lat    = lat_q.pop_front();
            r_cur    = req_q.pop_front();
            r_active = 1'b1;
            r_cyc    = 0;
          end
        end
        if (r_active) begin
          chk("req_addr", 128'(dmem_addr), 128'(r_cur.addr));
          chk("req_we", 128'(dmem_we), 128'(r_cur.we));
          chk("req_bmask", 128'(dmem_bmask), 128'(r_cur.bmask));
          if (r_cur.we)
            chk("req_wdata", 128'(dmem_wdata), 128'(r_cur.wdata));
          if (r_cyc == r_lat) begin
            dmem_ack   = 1'b1;
            wv         = dev_rd(dmem_addr);
            dmem_rdata = wv;
            if (dmem_we) begin
              for (int i = 0; i < 4; i++)
                if (dmem_bmask[i]) wv[8*i +: 8] = dmem_wdata[8*i +: 8];
              dev_mem[int'(dmem_addr)] = wv;
            end
            r_active = 1'b0;
          end else if (r_cyc == TIMEOUT - 1) begin
            r_active = 1'b0;
          end else begin
            r_cyc++;
          end
        end
      end else begin
        if (r_active) begin
          chk("req_dropped_early", 128'(r_cyc), 128'(r_lat));
          r_active = 1'b0;
        end
        dmem_ack   = stray_ack;
        dmem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard whenever W presents an entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (!i_rst_n) continue;
      if (valid_w) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_w", {127'd0, valid_w}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("w_pc", 128'(pc_w), 128'(e.pc));
          chk("w_rd", 128'(rd_w), 128'(e.rd));
          chk("w_rd_wren", 128'(rd_wren_w), 128'(e.rwe));
          chk("w_wb_sel", 128'(wb_sel_w), 128'(e.wbs));
          chk("w_alu", 128'(alu_data_w), 128'(e.alu));
          chk("w_ld", 128'(ld_data_w), 128'(e.ld));
          chk("w_misalign", 128'(misalign_w), 128'(e.mis));
          chk("w_bus_err", 128'(bus_err_w), 128'(e.berr));
          chk("w_stalls", 128'(stall_acc), 128'(e.stalls));
        end
        stall_acc = 0;
      end else begin
        chk("bubble_rd_wren", 128'(rd_wren_w), 128'd0);
      end
      if (stall_m) stall_acc++;
    end
  end

  initial begin
    int          kind;
    int          lat;
    logic [2:0]  f3;
    logic [31:0] addr;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("reset_dmem",
        128'({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_bmask, stall_m}),
        128'd0);
    chk("reset_w",
        128'({valid_w, pc_w, rd_w, rd_wren_w, wb_sel_w, alu_data_w,
              ld_data_w, misalign_w, bus_err_w}),
        128'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    issue(1, 2, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 0);
    issue(1, 2, 3'd0, 32'h103, 32'h000000A5, 5'd0, 1'b0, 0);
    issue(1, 1, 3'd0, 32'h103, 32'd0, 5'd7, 1'b1, 1);
    issue(1, 1, 3'd4, 32'h103, 32'd0, 5'd8, 1'b1, 0);
    issue(1, 2, 3'd1, 32'h102, 32'h00008001, 5'd0, 1'b0, 0);
    issue(1, 1, 3'd1, 32'h102, 32'd0, 5'd9, 1'b1, 3);
    issue(1, 1, 3'd2, 32'h101, 32'd0, 5'd10, 1'b1, 0);
    issue(1, 1, 3'd2, 32'h104, 32'd0, 5'd11, 1'b1, 99);
    issue(0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0);
    issue(0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0);
    stray_ack = 1'b1;
    issue(0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0);
    stray_ack = 1'b0;

    repeat (250) begin
      kind = int'($urandom % 3);
      lat  = ($urandom % 12 == 0) ? 20 : int'($urandom % 4);
      if (kind == 1) begin
        case ($urandom % 6)
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          4: f3 = 3'd5;
          default: f3 = 3'd3;
        endcase
      end else if (kind == 2) begin
        f3 = 3'($urandom % 3);
      end else begin
        f3 = 3'($urandom);
      end
      addr = (kind == 0) ? 32'($urandom) : 32'h100 + ($urandom % 16);
      issue(($urandom % 8) != 0, kind, f3, addr, $urandom,
            5'($urandom), 1'($urandom), lat);
    end

    issue(1, 1, 3'd2, 32'h108, 32'd0, 5'd12, 1'b1, 50);
    valid_e = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    flush = 1'b1;
    exp_q.delete();
    lat_q.delete();
    req_q.delete();
    stall_acc = 0;
    chk("midreq_reset_dmem", 128'({dmem_req, stall_m}), 128'd0);
    chk("midreq_reset_w",
        128'({valid_w, pc_w, rd_w, rd_wren_w, wb_sel_w, alu_data_w,
              ld_data_w, misalign_w, bus_err_w}),
        128'd0);
    i_rst_n   = 1'b1;
    stray_ack = 1'b1;
    @(posedge i_clk);
    #1;
    stray_ack = 1'b0;
    issue(1, 0, 3'd0, 32'h1234, 32'd0, 5'd5, 1'b1, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++)
      issue(0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 0);
    chk("drain_w", 128'(exp_q.size()), 128'd0);
    chk("drain_req", 128'(lat_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
